// File: rtl/nested_stack_guard.sv
// -----------------------------------------------------------------------------
// nested_stack_guard
//
// Tracks nested UCC invocations with a base-pointer stack and raises a
// registered violation request (reset) toward the system reset tree when:
//   - a write lands at or above the current frame's base pointer
//     (the stack grows down, so that region belongs to a caller),
//   - nesting overflows or underflows,
//   - entry and exit pulse in the same cycle,
//   - anything other than a clean fetch from RESET_HANDLER happens in RST.
//
// Optional feature macro: NESTED_STACK_GUARD_STICKY_EN
//   defined   : the first violation latches reset/viol_cause until
//               system_reset, and the stack freezes while latched.
//   undefined : reset/viol_cause re-evaluate every cycle.
//
// Ports:
//   clk            in   clock, rising edge
//   system_reset   in   synchronous active-high reset
//   data_addr      in   data-bus address           [ADDR_W]
//   data_wr        in   data write strobe
//   pc             in   program counter            [ADDR_W]
//   stack_pointer  in   SP, captured on entry      [ADDR_W]
//   ucc_state      in   00 notUCC, 01 inUCC, 10 IRQ, 11 RST
//   ucc_entry      in   one-cycle UCC entry pulse
//   ucc_exit       in   one-cycle UCC exit pulse
//   reset          out  registered violation request
//   viol_cause     out  cause code (000 when reset is low)
//   depth          out  current nesting level       [clog2(DEPTH+1)]
//   base_pointer   out  top-of-stack base pointer   [ADDR_W], 0 at depth 0
//
// Cause codes: 001 frame, 010 overflow, 011 underflow, 100 RST handler,
//              101 simultaneous entry/exit.
// -----------------------------------------------------------------------------
module nested_stack_guard #(
    parameter int                ADDR_W        = 16,
    parameter int                DEPTH         = 4,
    parameter logic [ADDR_W-1:0] RESET_HANDLER = '0,
    localparam int               DW            = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              system_reset,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic              data_wr,
    input  logic [ADDR_W-1:0] pc,
    input  logic [ADDR_W-1:0] stack_pointer,
    input  logic [1:0]        ucc_state,
    input  logic              ucc_entry,
    input  logic              ucc_exit,
    output logic              reset,
    output logic [2:0]        viol_cause,
    output logic [DW-1:0]     depth,
    output logic [ADDR_W-1:0] base_pointer
);

    localparam int            IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [DW-1:0] DEPTH_C = DW'(DEPTH);
    localparam logic [1:0]    ST_RST  = 2'b11;

    localparam logic [2:0] C_NONE  = 3'b000;
    localparam logic [2:0] C_FRAME = 3'b001;
    localparam logic [2:0] C_OVF   = 3'b010;
    localparam logic [2:0] C_UDF   = 3'b011;
    localparam logic [2:0] C_RST   = 3'b100;
    localparam logic [2:0] C_PROTO = 3'b101;

    logic [ADDR_W-1:0] r_bp [DEPTH];
    logic [DW-1:0]     r_depth;
    logic              r_viol;
    logic [2:0]        r_cause;

    logic [DW-1:0]     w_depth_m1;
    logic [IW-1:0]     w_top_idx;
    logic [IW-1:0]     w_push_idx;
    logic [ADDR_W-1:0] w_top_bp;
    logic              w_in_rst;
    logic              w_entry_only;
    logic              w_exit_only;
    logic              w_both;
    logic              w_frame_viol;
    logic              w_rst_viol;
    logic              w_ovf;
    logic              w_udf;
    logic              w_stack_en;
    logic              w_push;
    logic              w_pop;
    logic              w_viol;
    logic [2:0]        w_cause;

    assign w_depth_m1 = r_depth - DW'(1);
    assign w_top_idx  = w_depth_m1[IW-1:0];
    assign w_push_idx = r_depth[IW-1:0];
    // Index is only meaningful when depth > 0; the mux hides the wrapped index.
    assign w_top_bp   = (r_depth != '0) ? r_bp[w_top_idx] : '0;

    assign w_in_rst     = (ucc_state == ST_RST);
    assign w_entry_only = ucc_entry && !ucc_exit;
    assign w_exit_only  = ucc_exit && !ucc_entry;
    assign w_both       = ucc_entry && ucc_exit;

    // Uses the pre-edge base pointer, so a same-cycle push/pop does not affect it.
    assign w_frame_viol = !w_in_rst && (r_depth != '0) && data_wr
                          && !(data_addr < w_top_bp);
    assign w_rst_viol   = w_in_rst && ((pc != RESET_HANDLER) || data_wr);
    assign w_ovf        = w_entry_only && (r_depth == DEPTH_C);
    assign w_udf        = w_exit_only && (r_depth == '0);

    // An RST violation suppresses stack motion for that cycle; a latched
    // sticky violation freezes the stack entirely.
`ifdef NESTED_STACK_GUARD_STICKY_EN
    assign w_stack_en = !w_rst_viol && !r_viol;
`else
    assign w_stack_en = !w_rst_viol;
`endif

    assign w_push = w_stack_en && w_entry_only && (r_depth < DEPTH_C);
    assign w_pop  = w_stack_en && w_exit_only && (r_depth != '0);

    always_comb begin
        w_viol  = 1'b0;
        w_cause = C_NONE;
        if (w_rst_viol) begin
            w_viol  = 1'b1;
            w_cause = C_RST;
        end else if (w_ovf) begin
            w_viol  = 1'b1;
            w_cause = C_OVF;
        end else if (w_udf) begin
            w_viol  = 1'b1;
            w_cause = C_UDF;
        end else if (w_both) begin
            w_viol  = 1'b1;
            w_cause = C_PROTO;
        end else if (w_frame_viol) begin
            w_viol  = 1'b1;
            w_cause = C_FRAME;
        end
    end

    always_ff @(posedge clk) begin
        if (system_reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_bp[i] <= '0;
            end
            r_depth <= '0;
            r_viol  <= 1'b0;
            r_cause <= C_NONE;
        end else begin
            if (w_push) begin
                r_bp[w_push_idx] <= stack_pointer;
                r_depth          <= r_depth + DW'(1);
            end else if (w_pop) begin
                r_depth <= w_depth_m1;
            end
`ifdef NESTED_STACK_GUARD_STICKY_EN
            if (!r_viol) begin
                r_viol  <= w_viol;
                r_cause <= w_cause;
            end
`else
            r_viol  <= w_viol;
            r_cause <= w_cause;
`endif
        end
    end

    assign reset        = r_viol;
    assign viol_cause   = r_cause;
    assign depth        = r_depth;
    assign base_pointer = w_top_bp;

endmodule

// File: tb/tb_nested_stack_guard.sv
// -----------------------------------------------------------------------------
// Directed bench for nested_stack_guard (default, non-sticky build,
// DEPTH=4, ADDR_W=16, RESET_HANDLER=0). Inputs change #1 after a rising
// edge; outputs are checked #1 after the following rising edge.
// -----------------------------------------------------------------------------
module tb_nested_stack_guard;

  logic        clk = 1'b0;
  logic        system_reset;
  logic [15:0] data_addr;
  logic        data_wr;
  logic [15:0] pc;
  logic [15:0] stack_pointer;
  logic [1:0]  ucc_state;
  logic        ucc_entry;
  logic        ucc_exit;
  logic        reset;
  logic [2:0]  viol_cause;
  logic [2:0]  depth;
  logic [15:0] base_pointer;

  int n_checks = 0;
  int n_fail   = 0;

  nested_stack_guard #(
    .ADDR_W       (16),
    .DEPTH        (4),
    .RESET_HANDLER(16'h0000)
  ) dut (
    .clk          (clk),
    .system_reset (system_reset),
    .data_addr    (data_addr),
    .data_wr      (data_wr),
    .pc           (pc),
    .stack_pointer(stack_pointer),
    .ucc_state    (ucc_state),
    .ucc_entry    (ucc_entry),
    .ucc_exit     (ucc_exit),
    .reset        (reset),
    .viol_cause   (viol_cause),
    .depth        (depth),
    .base_pointer (base_pointer)
  );

  always #5 clk = ~clk;

  // ---- driver tasks ----
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    data_wr   = 1'b0;
    ucc_entry = 1'b0;
    ucc_exit  = 1'b0;
  endtask

  task automatic do_entry(input logic [15:0] sp);
    ucc_entry     = 1'b1;
    stack_pointer = sp;
    tick();
    idle_inputs();
  endtask

  task automatic do_exit();
    ucc_exit = 1'b1;
    tick();
    idle_inputs();
  endtask

  task automatic do_write(input logic [15:0] addr);
    data_wr   = 1'b1;
    data_addr = addr;
    tick();
    idle_inputs();
  endtask

  // ---- scenario tasks ----
  task automatic test_reset();
    system_reset = 1'b1;
    tick();
    tick();
    system_reset = 1'b0;
    n_checks++; if (reset !== 1'b0) begin n_fail++; $display("FAIL reset_reset got=%b exp=0", reset); end
    n_checks++; if (viol_cause !== 3'b000) begin n_fail++; $display("FAIL reset_cause got=%b exp=000", viol_cause); end
    n_checks++; if (depth !== 3'd0) begin n_fail++; $display("FAIL reset_depth got=%0d exp=0", depth); end
    n_checks++; if (base_pointer !== 16'h0000) begin n_fail++; $display("FAIL reset_bp got=%h exp=0000", base_pointer); end
  endtask

  task automatic test_nested_legal();
    ucc_state = 2'b01;
    do_entry(16'h4000);
    n_checks++; if (depth !== 3'd1) begin n_fail++; $display("FAIL nest_depth1 got=%0d exp=1", depth); end
    n_checks++; if (base_pointer !== 16'h4000) begin n_fail++; $display("FAIL nest_bp1 got=%h exp=4000", base_pointer); end
    do_entry(16'h3F00);
    do_write(16'h3EFE);
    n_checks++; if (reset !== 1'b0) begin n_fail++; $display("FAIL nest_legal_reset got=%b exp=0", reset); end
    n_checks++; if (depth !== 3'd2) begin n_fail++; $display("FAIL nest_depth2 got=%0d exp=2", depth); end
    n_checks++; if (base_pointer !== 16'h3F00) begin n_fail++; $display("FAIL nest_bp2 got=%h exp=3f00", base_pointer); end
    do_write(16'h3EFF);
    n_checks++; if (reset !== 1'b0) begin n_fail++; $display("FAIL nest_edge_legal got=%b exp=0", reset); end
  endtask

  task automatic test_caller_frame();
    do_write(16'h3F00);
    n_checks++; if (reset !== 1'b1) begin n_fail++; $display("FAIL frame_reset got=%b exp=1", reset); end
    n_checks++; if (viol_cause !== 3'b001) begin n_fail++; $display("FAIL frame_cause got=%b exp=001", viol_cause); end
    tick();
    n_checks++; if (reset !== 1'b0) begin n_fail++; $display("FAIL frame_drop_reset got=%b exp=0", reset); end
    n_checks++; if (viol_cause !== 3'b000) begin n_fail++; $display("FAIL frame_drop_cause got=%b exp=000", viol_cause); end
    do_write(16'hFFFF);
    n_checks++; if (viol_cause !== 3'b001) begin n_fail++; $display("FAIL frame_high_cause got=%b exp=001", viol_cause); end
  endtask

  task automatic test_overflow();
    do_entry(16'h3E00);
    do_entry(16'h3D00);
    n_checks++; if (depth !== 3'd4) begin n_fail++; $display("FAIL ovf_depth_full got=%0d exp=4", depth); end
    n_checks++; if (reset !== 1'b0) begin n_fail++; $display("FAIL ovf_full_reset got=%b exp=0", reset); end
    // fifth entry together with a frame violation: overflow outranks frame
    ucc_entry     = 1'b1;
    stack_pointer = 16'h3C00;
    data_wr       = 1'b1;
    data_addr     = 16'h3D00;
    tick();
    idle_inputs();
    n_checks++; if (viol_cause !== 3'b010) begin n_fail++; $display("FAIL ovf_cause got=%b exp=010", viol_cause); end
    n_checks++; if (depth !== 3'd4) begin n_fail++; $display("FAIL ovf_depth got=%0d exp=4", depth); end
    n_checks++; if (base_pointer !== 16'h3D00) begin n_fail++; $display("FAIL ovf_bp got=%h exp=3d00", base_pointer); end
  endtask

  task automatic test_underflow();
    logic [15:0] exp_bp [4];
    exp_bp[0] = 16'h0000;
    exp_bp[1] = 16'h4000;
    exp_bp[2] = 16'h3F00;
    exp_bp[3] = 16'h3E00;
    for (int d = 3; d >= 0; d--) begin
      do_exit();
      n_checks++; if (depth !== 3'(d)) begin n_fail++; $display("FAIL pop_depth got=%0d exp=%0d", depth, d); end
      n_checks++; if (base_pointer !== exp_bp[d]) begin n_fail++; $display("FAIL pop_bp got=%h exp=%h", base_pointer, exp_bp[d]); end
    end
    do_exit();
    n_checks++; if (viol_cause !== 3'b011) begin n_fail++; $display("FAIL udf_cause got=%b exp=011", viol_cause); end
    n_checks++; if (depth !== 3'd0) begin n_fail++; $display("FAIL udf_depth got=%0d exp=0", depth); end
    // writes at depth 0 are never checked
    do_write(16'hFFFF);
    n_checks++; if (reset !== 1'b0) begin n_fail++; $display("FAIL depth0_write got=%b exp=0", reset); end
  endtask

  task automatic test_simultaneous();
    do_entry(16'h4000);
    ucc_entry     = 1'b1;
    ucc_exit      = 1'b1;
    stack_pointer = 16'h1234;
    tick();
    idle_inputs();
    n_checks++; if (viol_cause !== 3'b101) begin n_fail++; $display("FAIL both_cause got=%b exp=101", viol_cause); end
    n_checks++; if (depth !== 3'd1) begin n_fail++; $display("FAIL both_depth got=%0d exp=1", depth); end
    n_checks++; if (base_pointer !== 16'h4000) begin n_fail++; $display("FAIL both_bp got=%h exp=4000", base_pointer); end
  endtask

  task automatic test_rst_state();
    ucc_state = 2'b11;
    pc        = 16'h0000;
    tick();
    n_checks++; if (reset !== 1'b0) begin n_fail++; $display("FAIL rst_clean got=%b exp=0", reset); end
    pc = 16'h0002;
    tick();
    n_checks++; if (viol_cause !== 3'b100) begin n_fail++; $display("FAIL rst_pc_cause got=%b exp=100", viol_cause); end
    // bad pc + write above frame + entry: cause 100, entry suppressed
    ucc_entry     = 1'b1;
    stack_pointer = 16'h3000;
    data_wr       = 1'b1;
    data_addr     = 16'h5000;
    tick();
    idle_inputs();
    n_checks++; if (viol_cause !== 3'b100) begin n_fail++; $display("FAIL rst_concurrent got=%b exp=100", viol_cause); end
    n_checks++; if (depth !== 3'd1) begin n_fail++; $display("FAIL rst_no_push got=%0d exp=1", depth); end
    // legal pc, no write: entry still processed
    pc = 16'h0000;
    do_entry(16'h3000);
    n_checks++; if (reset !== 1'b0) begin n_fail++; $display("FAIL rst_legal_entry_reset got=%b exp=0", reset); end
    n_checks++; if (depth !== 3'd2) begin n_fail++; $display("FAIL rst_legal_push got=%0d exp=2", depth); end
    // a write at legal pc is itself an RST violation
    do_write(16'h0010);
    n_checks++; if (viol_cause !== 3'b100) begin n_fail++; $display("FAIL rst_write got=%b exp=100", viol_cause); end
  endtask

  task automatic test_irq();
    ucc_state = 2'b10;
    pc        = 16'h0100;
    do_write(16'h3000);
    n_checks++; if (viol_cause !== 3'b001) begin n_fail++; $display("FAIL irq_frame got=%b exp=001", viol_cause); end
    n_checks++; if (depth !== 3'd2) begin n_fail++; $display("FAIL irq_depth got=%0d exp=2", depth); end
  endtask

  task automatic test_reset_mid();
    ucc_state = 2'b01;
    do_entry(16'h2000);
    do_write(16'h2000);
    n_checks++; if (depth !== 3'd3) begin n_fail++; $display("FAIL mid_pre_depth got=%0d exp=3", depth); end
    n_checks++; if (reset !== 1'b1) begin n_fail++; $display("FAIL mid_pre_reset got=%b exp=1", reset); end
    system_reset  = 1'b1;
    ucc_entry     = 1'b1;
    stack_pointer = 16'h1000;
    tick();
    system_reset = 1'b0;
    idle_inputs();
    n_checks++; if (depth !== 3'd0) begin n_fail++; $display("FAIL mid_depth got=%0d exp=0", depth); end
    n_checks++; if (reset !== 1'b0) begin n_fail++; $display("FAIL mid_reset got=%b exp=0", reset); end
    n_checks++; if (viol_cause !== 3'b000) begin n_fail++; $display("FAIL mid_cause got=%b exp=000", viol_cause); end
    n_checks++; if (base_pointer !== 16'h0000) begin n_fail++; $display("FAIL mid_bp got=%h exp=0000", base_pointer); end
  endtask

  initial begin
    system_reset  = 1'b1;
    data_addr     = 16'h0000;
    data_wr       = 1'b0;
    pc            = 16'h0000;
    stack_pointer = 16'h0000;
    ucc_state     = 2'b00;
    ucc_entry     = 1'b0;
    ucc_exit      = 1'b0;

    test_reset();
    test_nested_legal();
    test_caller_frame();
    test_overflow();
    test_underflow();
    test_simultaneous();
    test_rst_state();
    test_irq();
    test_reset_mid();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
